// File: rtl/instruction_sequencer.sv
// instruction_sequencer: steps through a small program memory at a programmable
// rate. For each word it drives the register-file addresses, a one-cycle write
// strobe, and the full instruction word as the ALU opcode.
module instruction_sequencer #(
  parameter int          ADDR_WIDTH = 4,
  parameter int          TICK_DIV   = 150000000,
  parameter logic [15:0] HALT_WORD  = 16'hFFFF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Prog_We,
  input  logic [ADDR_WIDTH-1:0] Prog_Addr,
  input  logic [15:0]           Prog_Data,
  output logic [3:0]            Reg_Read_A,
  output logic [3:0]            Reg_Read_B,
  output logic [3:0]            Reg_Write,
  output logic                  Write_Enable,
  output logic [15:0]           OpCode,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  Busy,
  output logic                  Halted
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // A divider of 1 still needs a one-bit counter so the compare stays legal.
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]      TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_LAST   = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FETCH,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t                state_q, state_next;
  logic [ADDR_WIDTH-1:0] pc_q, pc_next;
  logic [15:0]           ir_q, ir_next;
  logic [CNT_W-1:0]      cnt_q, cnt_next;
  logic [15:0]           prog_mem [DEPTH];
  logic                  prog_write_ok;

  // Loading is only allowed while the sequencer is parked, so a running
  // program never sees its own words change underneath it.
  assign prog_write_ok = Prog_We && ((state_q == S_IDLE) || (state_q == S_HALTED));

  // Program memory write port; contents deliberately survive reset.
  always_ff @(posedge Clk) begin
    if (prog_write_ok) begin
      prog_mem[Prog_Addr] <= Prog_Data;
    end
  end

  // State, PC, instruction register and tick counter registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_next;
      pc_q    <= pc_next;
      ir_q    <= ir_next;
      cnt_q   <= cnt_next;
    end
  end

  // Next-state logic plus the write strobe, the only combinational output.
  always_comb begin
    state_next   = state_q;
    pc_next      = pc_q;
    ir_next      = ir_q;
    cnt_next     = cnt_q;
    Write_Enable = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          pc_next    = '0;
          cnt_next   = '0;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == TICK_LAST) begin
          cnt_next   = '0;
          state_next = S_FETCH;
        end else begin
          cnt_next = cnt_q + CNT_W'(1);
        end
      end
      S_FETCH: begin
        ir_next    = prog_mem[pc_q];
        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (ir_q == HALT_WORD) begin
          state_next = S_HALTED;
        end else begin
          Write_Enable = 1'b1;
          if (pc_q == PC_LAST) begin
            state_next = S_HALTED;
          end else begin
            pc_next    = pc_q + ADDR_WIDTH'(1);
            state_next = S_WAIT;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign Reg_Read_A = ir_q[11:8];
  assign Reg_Read_B = ir_q[3:0];
  assign Reg_Write  = ir_q[11:8];
  assign OpCode     = ir_q;
  assign PC         = pc_q;
  assign Busy       = (state_q == S_WAIT) || (state_q == S_FETCH) || (state_q == S_EXEC);
  assign Halted     = (state_q == S_HALTED);

endmodule
